uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//   UART transmit framer/serializer; opposite end of the UART_RX deserializer path.
//   Accepts one parallel word on a valid strobe and shifts out a frame on TX_OUT.
//   Frame order: start(0), data LSB-first, optional parity, stop(1).
//   Each bit is held for Prescale CLK cycles, so TX shares CLK and Prescale with RX.
// PARAMETERS
//   DATA_WIDTH   8   data bits per frame (1..16)
// PORTS
//   CLK         in   1           clock, all state on posedge
//   RST         in   1           reset, asynchronous, active-low
//   P_DATA      in   DATA_WIDTH  parallel word to send
//   Data_Valid  in   1           request; accepted only in a cycle with Busy=0
//   Prescale    in   6           CLK cycles per bit; 0 is treated as 1
//   PAR_TYP     in   1           0=even, 1=odd parity (ignored unless parity compiled in)
//   TX_OUT      out  1           serial line, idle high
//   Busy        out  1           high while a frame is on the line
// BEHAVIOUR
//   - Reset (async): TX_OUT=1, Busy=0, state IDLE, counters 0, shift reg 0.
//     Reset mid-frame aborts immediately; the line returns high with no glitch low.
//   - TX_OUT and Busy are registered outputs. No combinational path from any input.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept: at a posedge with state IDLE and Data_Valid=1, the block:
//     latches P_DATA into the shift register;
//     latches Prescale (0 becomes 1) into pre_q;
//     latches PAR_TYP and computes par_q = ^P_DATA ^ PAR_TYP;
//     sets TX_OUT=0 and Busy=1 at that same edge, and enters START.
//     Latency from the accepting edge to the start bit on the line is 0 cycles.
//   - Bit timer: 6-bit bit_cnt counts 0..pre_q-1. Each bit lasts exactly pre_q cycles.
//     The state/bit advances when bit_cnt == pre_q-1, and bit_cnt returns to 0.
//   - DATA: TX_OUT = shift[0]; the register shifts right at each bit boundary.
//     A 4-bit data index runs 0..DATA_WIDTH-1.
//     After the last bit the FSM goes to PARITY (if compiled in) or STOP.
//   - PARITY: TX_OUT = par_q for pre_q cycles.
//   - STOP: TX_OUT=1 for pre_q cycles. At the end: state IDLE, Busy=0, TX_OUT stays 1.
//   - Busy is high for exactly N*pre_q cycles, N = DATA_WIDTH+2 (+1 with parity).
//   - Data_Valid while Busy=1 is ignored; nothing is queued.
//     With Data_Valid held high, frames are separated by exactly 1 idle-high cycle
//     (the Busy=0 cycle in which the next word is accepted).
//   - Changes on Prescale, PAR_TYP or P_DATA after acceptance do not affect the
//     frame in flight.
//   - Illegal or unreachable FSM state: next state IDLE, TX_OUT=1, Busy=0.
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     the PARITY state exists; frame = start + DATA_WIDTH + parity + stop.
//   UART_TX_PARITY_EN undefined:
//     no PARITY state and no parity logic; PAR_TYP is unconnected internally;
//     frame = start + DATA_WIDTH + stop.
//   Port list is identical in both builds.
// TESTING
//   1. No macro, Prescale=8, P_DATA=0xA5, 1-cycle Data_Valid ->
//      TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles; Busy high exactly 80 cycles.
//   2. Macro on, Prescale=8, P_DATA=0xA5 ->
//      PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1; Busy high 88 cycles.
//   3. Data_Valid held high, P_DATA=0x3C then 0xC3 (no macro, Prescale=4) ->
//      two 40-cycle frames separated by 1 idle-high cycle; 0xC3 is latched at the gap edge.
//   4. Assert RST during data bit 3 of a frame ->
//      TX_OUT=1 and Busy=0 without waiting for a clock edge;
//      the next accepted word produces a complete, correct frame.
//   5. Prescale=0, P_DATA=0xFF (no macro) -> 10-cycle frame, each bit 1 cycle.
//      Prescale changed 8->2 mid-frame -> current frame keeps 8-cycle bits.
//   6. Data_Valid pulses while Busy=1 -> ignored; exactly one frame is emitted.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer/serializer.
// Sends start(0), DATA_WIDTH data bits LSB-first, optional parity and stop(1).
// Each bit lasts Prescale CLK cycles; a Prescale of 0 counts as 1.
// Build option: define UART_TX_PARITY_EN to add the parity bit (PAR_TYP 0=even, 1=odd).
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam logic [3:0] IDX_LAST = 4'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                state, state_nx;
    logic [5:0]            bit_cnt, bit_cnt_nx;
    logic [5:0]            pre_q, pre_nx;
    logic [3:0]            idx, idx_nx;
    logic [DATA_WIDTH-1:0] shift, shift_nx, shift_sh;
    logic                  tx_q, tx_nx;
    logic                  busy_q, busy_nx;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  par_q, par_nx;
`else
    logic                  unused_par_typ;
    assign unused_par_typ = PAR_TYP;
`endif

    assign bit_end  = (bit_cnt == pre_q - 6'd1);
    assign shift_sh = shift >> 1;
    assign TX_OUT   = tx_q;
    assign Busy     = busy_q;

    // State and datapath registers; async reset leaves the line idle high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            pre_q   <= '0;
            idx     <= '0;
            shift   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            pre_q   <= pre_nx;
            idx     <= idx_nx;
            shift   <= shift_nx;
            tx_q    <= tx_nx;
            busy_q  <= busy_nx;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_nx;
`endif
        end
    end

    // Next state plus next line/busy values, so both outputs come straight from flops.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        pre_nx     = pre_q;
        idx_nx     = idx;
        shift_nx   = shift;
        tx_nx      = tx_q;
        busy_nx    = busy_q;
`ifdef UART_TX_PARITY_EN
        par_nx     = par_q;
`endif
        case (state)
            S_IDLE: begin
                tx_nx      = 1'b1;
                busy_nx    = 1'b0;
                bit_cnt_nx = '0;
                idx_nx     = '0;
                if (Data_Valid) begin
                    // Start bit goes on the line at the accepting edge itself.
                    shift_nx = P_DATA;
                    pre_nx   = (Prescale == 6'd0) ? 6'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
                    par_nx   = ^P_DATA ^ PAR_TYP;
`endif
                    tx_nx    = 1'b0;
                    busy_nx  = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    idx_nx     = '0;
                    tx_nx      = shift[0];
                    state_nx   = S_DATA;
                end else begin
                    bit_cnt_nx = bit_cnt + 6'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx_nx    = par_q;
                        state_nx = S_PARITY;
`else
                        tx_nx    = 1'b1;
                        state_nx = S_STOP;
`endif
                    end else begin
                        idx_nx   = idx + 4'd1;
                        shift_nx = shift_sh;
                        tx_nx    = shift_sh[0];
                    end
                end else begin
                    bit_cnt_nx = bit_cnt + 6'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    tx_nx      = 1'b1;
                    state_nx   = S_STOP;
                end else begin
                    bit_cnt_nx = bit_cnt + 6'd1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_nx = '0;
                    tx_nx      = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = S_IDLE;
                end else begin
                    bit_cnt_nx = bit_cnt + 6'd1;
                end
            end
            default: begin
                state_nx   = S_IDLE;
                bit_cnt_nx = '0;
                tx_nx      = 1'b1;
                busy_nx    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: stimulus pushes expected frames, a monitor
// pops them when Busy rises and checks the line bit-by-bit, cycle-by-cycle.
module tb_uart_tx_frame;

    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          Data_Valid = 1'b0;
    logic [5:0]    Prescale = 6'd1;
    logic          PAR_TYP = 1'b0;
    logic          TX_OUT;
    logic          Busy;

    typedef struct {
        logic [DW-1:0] data;
        int            pre;
        bit            pt;
        int            gap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Prescale(Prescale), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nbits();
`ifdef UART_TX_PARITY_EN
        return DW + 3;
`else
        return DW + 2;
`endif
    endfunction

    function automatic int eff_pre(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    // Frame as a list of line levels, one per bit period.
    function automatic void frame_bits(input exp_t e, output bit b[$]);
        b = {};
        b.push_back(1'b0);
        for (int i = 0; i < DW; i++) b.push_back(e.data[i]);
`ifdef UART_TX_PARITY_EN
        b.push_back((^e.data) ^ e.pt);
`endif
        b.push_back(1'b1);
    endfunction

    function automatic void push(input logic [DW-1:0] d, input int p, input bit pt, input int gap);
        exp_t e;
        e.data = d; e.pre = eff_pre(p); e.pt = pt; e.gap = gap;
        sb.push_back(e);
    endfunction

    // One-cycle request; inputs are scrambled afterwards to prove the frame ignores them.
    task automatic send(input logic [DW-1:0] d, input int p, input bit pt);
        @(negedge CLK);
        P_DATA = d; Prescale = p[5:0]; PAR_TYP = pt; Data_Valid = 1'b1;
        push(d, p, pt, -1);
        @(negedge CLK);
        Data_Valid = 1'b0;
        P_DATA     = DW'($urandom);
        Prescale   = 6'($urandom_range(1, 63));
        PAR_TYP    = 1'($urandom);
    endtask

    task automatic wait_frame(input int p);
        repeat (nbits() * eff_pre(p) + 2) @(negedge CLK);
    endtask

    // Monitor: checks idle line, frame spacing, every frame cycle, and Busy fall.
    initial begin
        int idle;
        idle = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                idle = 0;
                continue;
            end
            if (!Busy) begin
                idle++;
                chk("idle_line_high", int'(TX_OUT), 1);
            end else if (sb.size() == 0) begin
                chk("spurious_frame", 1, 0);
                for (int k = 0; k < 2000 && Busy && RST; k++) @(negedge CLK);
                idle = 0;
            end else begin
                exp_t e;
                bit   b[$];
                int   tot;
                bit   aborted;
                e = sb.pop_front();
                if (e.gap >= 0) chk("frame_gap", idle, e.gap);
                frame_bits(e, b);
                tot = b.size() * e.pre;
                aborted = 1'b0;
                for (int c = 0; c < tot; c++) begin
                    if (c > 0) @(negedge CLK);
                    if (!RST) begin
                        aborted = 1'b1;
                        break;
                    end
                    chk("busy_in_frame", int'(Busy), 1);
                    chk("tx_bit", int'(TX_OUT), int'(b[c / e.pre]));
                end
                if (!aborted) begin
                    @(negedge CLK);
                    if (RST) begin
                        chk("busy_end", int'(Busy), 0);
                        chk("tx_end", int'(TX_OUT), 1);
                    end
                    idle = 1;
                end else begin
                    idle = 0;
                end
            end
        end
    end

    initial begin
        // Reset state while RST is asserted.
        #12;
        chk("reset_tx", int'(TX_OUT), 1);
        chk("reset_busy", int'(Busy), 0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);

        // Directed frames: 0xA5 at 8 cycles/bit, both parity types.
        send(8'hA5, 8, 1'b0); wait_frame(8);
        send(8'hA5, 8, 1'b1); wait_frame(8);

        // Prescale 0 behaves as 1.
        send(8'hFF, 0, 1'b0); wait_frame(0);

        // Prescale changed mid-frame must not stretch/shrink bits.
        send(8'h96, 8, 1'b1);
        Prescale = 6'd2;
        wait_frame(8);

        // Back-to-back with Data_Valid held: second word latched at the gap edge.
        @(negedge CLK);
        P_DATA = 8'h3C; Prescale = 6'd4; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        push(8'h3C, 4, 1'b0, -1);
        @(negedge CLK);
        P_DATA = 8'hC3;
        push(8'hC3, 4, 1'b0, 1);
        repeat (nbits() * 4 + 5) @(negedge CLK);
        Data_Valid = 1'b0;
        wait_frame(4);

        // Requests while Busy are dropped.
        send(8'h5A, 8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            repeat (15) @(negedge CLK);
            P_DATA = DW'($urandom); Data_Valid = 1'b1;
            @(negedge CLK);
            Data_Valid = 1'b0;
        end
        wait_frame(8);

        // Reset in the middle of data bit 3: line goes high without a clock edge.
        send(8'h00, 8, 1'b0);
        repeat (33) @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_tx", int'(TX_OUT), 1);
        chk("async_rst_busy", int'(Busy), 0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);
        send(8'h81, 3, 1'b1); wait_frame(3);

        // Randomized frames with random idle gaps.
        for (int n = 0; n < 16; n++) begin
            logic [DW-1:0] d;
            int            p;
            bit            pt;
            d  = DW'($urandom);
            p  = $urandom_range(0, 12);
            pt = 1'($urandom);
            send(d, p, pt);
            wait_frame(p);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
